// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger handshake (master tlu_tx and DUT responder).
package tlu_pkg;

  localparam int unsigned TLU_TRIG_ID_WIDTH = 15;
  // Sampling at the end of the high phase needs room for the synchronizer and TLU turnaround.
  localparam int unsigned TLU_MIN_CLK_DIV   = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWaitLow,
    StClkHi,
    StClkLo,
    StStore,
    StRelease
  } tlu_state_e;

endpackage

// File: rtl/tlu_sync_edge.sv
// N-stage synchronizer for an asynchronous level, with a rising-edge strobe on the synced value.
module tlu_sync_edge #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Shift the raw input down the chain and remember the last synced level for edge detection.
  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < Stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[Stages-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;

endmodule

// File: rtl/tlu_dut_responder.sv
// DUT side of the TLU trigger handshake: busy/clock generation, serial ID capture,
// one-entry valid/ready output buffer and ID continuity checking.
module tlu_dut_responder
  import tlu_pkg::*;
#(
  parameter int unsigned TRIG_ID_WIDTH = TLU_TRIG_ID_WIDTH,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     SYS_CLK,
  input  logic                     SYS_RST,
  input  logic                     ENABLE,
  input  logic [7:0]               CONF_CLK_DIV,
  input  logic [15:0]              CONF_TIMEOUT,
  input  logic                     DUT_BUSY,
  input  logic                     TLU_TRIGGER,
  input  logic                     TLU_RESET,
  output logic                     TLU_BUSY,
  output logic                     TLU_CLOCK,
  output logic                     TRIG_VALID,
  input  logic                     TRIG_READY,
  output logic [TRIG_ID_WIDTH-1:0] TRIG_ID,
  output logic                     TRIG_ERR,
  output logic [7:0]               TIMEOUT_CNT,
  output logic [7:0]               MISMATCH_CNT
);

  localparam int unsigned BitCntW = $clog2(TRIG_ID_WIDTH + 1);

  logic trig, trig_rise, rst_lvl, rst_rise;
  logic unused_sync;

  tlu_sync_edge #(.Stages(SYNC_STAGES)) u_sync_trig (
    .clk_i  (SYS_CLK),
    .rst_i  (SYS_RST),
    .d_i    (TLU_TRIGGER),
    .q_o    (trig),
    .rise_o (trig_rise)
  );

  tlu_sync_edge #(.Stages(SYNC_STAGES)) u_sync_rst (
    .clk_i  (SYS_CLK),
    .rst_i  (SYS_RST),
    .d_i    (TLU_RESET),
    .q_o    (rst_lvl),
    .rise_o (rst_rise)
  );

  assign unused_sync = trig_rise ^ rst_lvl;

  tlu_state_e               state_q, state_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [TRIG_ID_WIDTH-1:0] sr_q, sr_d;
  logic [TRIG_ID_WIDTH-1:0] id_q, id_d;
  logic [TRIG_ID_WIDTH-1:0] exp_q, exp_d;
  logic                     err_q, err_d;
  logic                     valid_q, valid_d;
  logic                     first_q, first_d;
  logic [7:0]               tmo_cnt_q, tmo_cnt_d;
  logic [7:0]               mis_cnt_q, mis_cnt_d;

  logic [7:0]               div;
  logic                     phase_end;
  logic                     id_err;
  logic [TRIG_ID_WIDTH:0]   sr_ext;

  assign div       = (CONF_CLK_DIV < 8'(TLU_MIN_CLK_DIV)) ? 8'(TLU_MIN_CLK_DIV) : CONF_CLK_DIV;
  assign phase_end = (cnt_q == {8'h00, div - 8'd1});
  assign id_err    = !first_q && (sr_q != exp_q);
  // New bit enters at the MSB; after all bits the first (LSB) one sits at bit 0.
  assign sr_ext    = {trig, sr_q};

  // Handshake FSM, shift register, output buffer and ID check next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    id_d      = id_q;
    exp_d     = exp_q;
    err_d     = err_q;
    valid_d   = valid_q;
    first_d   = first_q;
    tmo_cnt_d = tmo_cnt_q;
    mis_cnt_d = mis_cnt_q;

    if (valid_q && TRIG_READY) valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ENABLE && trig) begin
          state_d = StWaitLow;
          cnt_d   = '0;
        end
      end
      StWaitLow: begin
        if (!trig) begin
          state_d   = StClkHi;
          cnt_d     = '0;
          bit_cnt_d = '0;
        end else if ((CONF_TIMEOUT != 16'h0000) && (cnt_q == CONF_TIMEOUT)) begin
          if (tmo_cnt_q != 8'hff) tmo_cnt_d = tmo_cnt_q + 8'd1;
          state_d = StRelease;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StClkHi: begin
        if (phase_end) begin
          sr_d      = sr_ext[TRIG_ID_WIDTH:1];
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          cnt_d     = '0;
          state_d   = StClkLo;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StClkLo: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = (bit_cnt_q == BitCntW'(TRIG_ID_WIDTH)) ? StStore : StClkHi;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStore: begin
        if (!valid_q || TRIG_READY) begin
          id_d    = sr_q;
          err_d   = id_err;
          exp_d   = sr_q + 1'b1;
          first_d = 1'b0;
          valid_d = 1'b1;
          if (id_err && (mis_cnt_q != 8'hff)) mis_cnt_d = mis_cnt_q + 8'd1;
          state_d = StRelease;
        end
      end
      StRelease: begin
        if (!DUT_BUSY && !trig) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A TLU reset restarts continuity checking without disturbing a running transaction.
    if (rst_rise) first_d = 1'b1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge SYS_CLK) begin
    if (SYS_RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      id_q      <= '0;
      exp_q     <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b1;
      tmo_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      id_q      <= id_d;
      exp_q     <= exp_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      tmo_cnt_q <= tmo_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign TLU_BUSY     = (state_q != StIdle);
  assign TLU_CLOCK    = (state_q == StClkHi);
  assign TRIG_VALID   = valid_q;
  assign TRIG_ID      = id_q;
  assign TRIG_ERR     = err_q;
  assign TIMEOUT_CNT  = tmo_cnt_q;
  assign MISMATCH_CNT = mis_cnt_q;

endmodule
